phase_counter_bank: RTL

PHASE_COUNTER_BANK -- requirements
Module: phase_counter_bank

---
 rtl/phase_counter_bank.sv | 128 ++++++++++++
 1 files changed

// File: rtl/phase_counter_bank.sv
// Bank of phase accumulators sharing one step mode, with per-channel offsets.
// Define PHASE_BOUNCE_EN to build the mode 10 bounce (triangle) stepping.
module phase_counter_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      sync,
    input  logic [1:0]                mode,
    input  logic                      cfg_we,
    input  logic [CW-1:0]             cfg_ch,
    input  logic [WIDTH-1:0]          cfg_incr,
    input  logic [WIDTH-1:0]          cfg_offset,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       wrap,
    output logic                      valid
);
    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    logic [WIDTH-1:0]    acc    [CHANNELS];
    logic [WIDTH-1:0]    incr   [CHANNELS];
    logic [WIDTH-1:0]    offset [CHANNELS];
    logic [WIDTH-1:0]    acc_nx [CHANNELS];
    logic [WIDTH:0]      sum    [CHANNELS];
    logic [CHANNELS-1:0] wrap_nx;

`ifdef PHASE_BOUNCE_EN
    localparam logic [WIDTH:0]   TWO_MAX = {{WIDTH{1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] HALF    = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CHANNELS-1:0] dir;
    logic [CHANNELS-1:0] dir_nx;
    logic [WIDTH-1:0]    incr_b [CHANNELS];
    logic [WIDTH:0]      up_b   [CHANNELS];
`endif

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sum[c]     = {1'b0, acc[c]} + {1'b0, incr[c]};
            acc_nx[c]  = acc[c];
            wrap_nx[c] = 1'b0;
`ifdef PHASE_BOUNCE_EN
            dir_nx[c] = dir[c];
            // Capping the step at half range keeps a reflection in bounds.
            incr_b[c] = (incr[c] > HALF) ? HALF : incr[c];
            up_b[c]   = {1'b0, acc[c]} + {1'b0, incr_b[c]};
`endif
            if (en) begin
                unique case (mode)
`ifdef PHASE_BOUNCE_EN
                    MODE_UP: begin
                        acc_nx[c]  = sum[c][WIDTH-1:0];
                        wrap_nx[c] = sum[c][WIDTH];
                    end
                    MODE_BOUNCE: begin
                        if (!dir[c]) begin
                            if (!up_b[c][WIDTH]) begin
                                acc_nx[c] = up_b[c][WIDTH-1:0];
                            end else begin
                                acc_nx[c]  = WIDTH'(TWO_MAX - up_b[c]);
                                dir_nx[c]  = 1'b1;
                                wrap_nx[c] = 1'b1;
                            end
                        end else if (acc[c] >= incr_b[c]) begin
                            acc_nx[c] = acc[c] - incr_b[c];
                        end else begin
                            acc_nx[c]  = incr_b[c] - acc[c];
                            dir_nx[c]  = 1'b0;
                            wrap_nx[c] = 1'b1;
                        end
                    end
`else
                    MODE_UP, MODE_BOUNCE: begin
                        acc_nx[c]  = sum[c][WIDTH-1:0];
                        wrap_nx[c] = sum[c][WIDTH];
                    end
`endif
                    MODE_DOWN: begin
                        acc_nx[c]  = acc[c] - incr[c];
                        wrap_nx[c] = incr[c] > acc[c];
                    end
                    MODE_HOLD: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c]    <= '0;
                incr[c]   <= WIDTH'(1);
                offset[c] <= '0;
            end
`ifdef PHASE_BOUNCE_EN
            dir <= '0;
`endif
            wrap  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= en & ~sync;
            wrap  <= sync ? '0 : wrap_nx;
`ifdef PHASE_BOUNCE_EN
            dir   <= sync ? '0 : dir_nx;
`endif
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= sync ? '0 : acc_nx[c];
                // Out-of-range indices match no channel and are dropped.
                if (cfg_we && cfg_ch == CW'(c)) begin
                    incr[c]   <= cfg_incr;
                    offset[c] <= cfg_offset;
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_count
        assign count[g*WIDTH +: WIDTH] = acc[g] + offset[g];
    end

endmodule
